// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the nibble-serial CLA adder sequencer.
package cla_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NIBBLE_W = 4;

  // Number of nibble steps needed to cover a given operand width.
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer_cla4.sv
// 4-bit carry-lookahead adder slice shared by the nibble sequencer.
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Wide adder built from one shared 4-bit CLA, one nibble per clock, LSB first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one nibble added per edge; last nibble returns to IDLE with done
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = nibbles(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "cla_nibble_sequencer: WIDTH must be a multiple of 4 in 4..64");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, a_sr_n;
  logic [WIDTH-1:0] b_sr, b_sr_n;
  logic             carry_r, carry_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             busy_n, done_n, cout_n;
  logic [WIDTH-1:0] sum_n;

  logic [NIBBLE_W-1:0] cla_sum;
  logic                cla_cout;

  CLA_4bit u_cla (
    .a    (a_sr[NIBBLE_W-1:0]),
    .b    (b_sr[NIBBLE_W-1:0]),
    .cin  (carry_r),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state   <= state_n;
      a_sr    <= a_sr_n;
      b_sr    <= b_sr_n;
      carry_r <= carry_n;
      idx     <= idx_n;
      busy    <= busy_n;
      done    <= done_n;
      sum     <= sum_n;
      cout    <= cout_n;
    end
  end

  // Next-state logic: accept in IDLE, shift one nibble per edge in RUN.
  always_comb begin
    state_n = state;
    a_sr_n  = a_sr;
    b_sr_n  = b_sr;
    carry_n = carry_r;
    idx_n   = idx;
    busy_n  = busy;
    done_n  = 1'b0;
    sum_n   = sum;
    cout_n  = cout;
    case (state)
      IDLE: begin
        if (start) begin
          a_sr_n  = op_a;
          b_sr_n  = op_b;
          carry_n = cin;
          idx_n   = '0;
          busy_n  = 1'b1;
          sum_n   = '0;
          cout_n  = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        // Result nibbles enter at the top so the LSB nibble ends at bit 0.
        sum_n = sum >> NIBBLE_W;
        sum_n[WIDTH-1 -: NIBBLE_W] = cla_sum;
        a_sr_n  = a_sr >> NIBBLE_W;
        b_sr_n  = b_sr >> NIBBLE_W;
        carry_n = cla_cout;
        idx_n   = idx + IDX_W'(1);
        if (idx == LAST_IDX) begin
          cout_n  = cla_cout;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Scoreboard bench: stimulus pushes expected {cout,sum}; monitors pop on done.
module tb_cla_nibble_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // 16-bit DUT: directed tests and random
  logic        start;
  logic [15:0] op_a, op_b;
  logic        cin;
  logic        busy, done, cout;
  logic [15:0] sum;

  // 4-bit and 32-bit DUTs: random regression only
  logic        startx;
  logic [3:0]  a4, b4;
  logic        c4;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;
  logic [31:0] a32, b32;
  logic        c32;
  logic        busy32, done32, cout32;
  logic [31:0] sum32;

  cla_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  cla_nibble_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(startx), .op_a(a4), .op_b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  cla_nibble_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(startx), .op_a(a32), .op_b(b32), .cin(c32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [32:0] q32[$];
  int acc16 = 0, acc4 = 0, acc32 = 0;
  int d16 = 0, d4 = 0, d32 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: done with no pending operation", nm);
  endtask

  // Monitors: pop the expected result whenever a DUT pulses done.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      d16++;
      if (q16.size() == 0) unexpected("done16");
      else chk("result16", {47'b0, cout, sum}, {47'b0, q16.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      d4++;
      if (q4.size() == 0) unexpected("done4");
      else chk("result4", {59'b0, cout4, sum4}, {59'b0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      d32++;
      if (q32.size() == 0) unexpected("done32");
      else chk("result32", {31'b0, cout32, sum32}, {31'b0, q32.pop_front()});
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int t0);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    q16.push_back({1'b0, a} + {1'b0, b} + {16'b0, c});
    acc16++;
    t0 = cyc;
  endtask

  // Waits (bounded) for done on the 16-bit DUT, counting busy samples on the way.
  task automatic wait_done(input int t0, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    int t0, lat, bc, bc0, snap;
    start = 1'b0; startx = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    a4 = '0; b4 = '0; c4 = 1'b0;
    a32 = '0; b32 = '0; c32 = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {63'b0, busy}, 64'd0);
      chk("idle_done", {63'b0, done}, 64'd0);
      chk("idle_sum",  {48'b0, sum}, 64'd0);
      chk("idle_cout", {63'b0, cout}, 64'd0);
    end

    // 0xFFFF + 0x0001: full carry ripple across all nibbles
    issue(16'hFFFF, 16'h0001, 1'b0, t0);
    @(negedge clk);
    start = 1'b0;
    bc0 = (busy === 1'b1) ? 1 : 0;
    wait_done(t0, lat, bc);
    chk("ripple_latency", lat, 64'd5);
    chk("ripple_busy_cycles", bc0 + bc, 64'd4);

    // 0x1234 + 0x4321 + 1, with a start pulse while busy that must be ignored
    issue(16'h1234, 16'h4321, 1'b1, t0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat, bc);
    chk("ignore_latency", lat, 64'd5);
    repeat (3) @(negedge clk);
    chk("held_sum", {48'b0, sum}, 64'h5556);
    chk("held_cout", {63'b0, cout}, 64'd0);
    chk("held_busy", {63'b0, busy}, 64'd0);

    // start held high: back-to-back operations
    issue(16'h8000, 16'h8000, 1'b0, t0);
    @(negedge clk);
    op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0;
    q16.push_back(17'h00100);
    acc16++;
    wait_done(t0, lat, bc);
    chk("b2b_first_latency", lat, 64'd5);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat, bc);
    chk("b2b_done_spacing", lat, 64'd5);
    repeat (2) @(negedge clk);

    // Reset at the 3rd RUN edge aborts the run without a done
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    snap = d16;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_sum",  {48'b0, sum}, 64'd0);
    chk("abort_cout", {63'b0, cout}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", d16, snap);

    issue(16'h0001, 16'h0001, 1'b0, t0);
    @(negedge clk);
    start = 1'b0;
    wait_done(t0, lat, bc);
    chk("post_abort_latency", lat, 64'd5);
    repeat (2) @(negedge clk);

    // Random regression on all three widths
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      c4 = 1'($urandom_range(0, 1));
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1));
      start = 1'b1; startx = 1'b1;
      q16.push_back({1'b0, op_a} + {1'b0, op_b} + {16'b0, cin});
      q4.push_back({1'b0, a4} + {1'b0, b4} + {4'b0, c4});
      q32.push_back({1'b0, a32} + {1'b0, b32} + {32'b0, c32});
      acc16++; acc4++; acc32++;
      @(negedge clk);
      start = 1'b0; startx = 1'b0;
      for (int w = 0; w < 30; w++) begin
        #1;
        if (d16 >= acc16 && d4 >= acc4 && d32 >= acc32) break;
        @(negedge clk);
      end
      if (!(d16 >= acc16 && d4 >= acc4 && d32 >= acc32)) begin
        n_cmp++;
        n_err++;
        $display("FAIL random_timeout: op %0d done counts %0d/%0d/%0d required %0d/%0d/%0d",
                 i, d16, d4, d32, acc16, acc4, acc32);
        break;
      end
    end

    repeat (12) @(negedge clk);
    chk("done_count16", d16, acc16);
    chk("done_count4",  d4,  acc4);
    chk("done_count32", d32, acc32);
    chk("queue16_empty", q16.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
